serial_add_sub: RTL and testbench

Parametrised, multi-cycle two's-complement adder/subtractor that processes `WIDTH`-bit operands `SLICE` bits per clock through a start/busy/done handshake. It reports carry-out and signed overflow, and optionally saturates on overflow. It replaces the fixed 4-bit combinational ripple-carry adder/subtractor where operand width must scale without a long combinational carry chain.

---
 rtl/serial_add_sub.sv | 139 +++++++++++++
 tb/tb_serial_add_sub.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Multi-cycle two's-complement adder/subtractor: adds SLICE bits per clock, LSB first,
// reporting carry-out and signed overflow with optional saturation of the result.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic             sat,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             carry,
  output logic             overflow
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [WIDTH-1:0]  a_reg, a_next;
  logic [WIDTH-1:0]  b_reg, b_next;
  logic [WIDTH-1:0]  res_reg, res_next;
  logic              c_reg, c_next;
  logic              sat_reg, sat_next;
  logic [WIDTH-1:0]  sum_reg, sum_next;
  logic              carry_reg, carry_next;
  logic              ov_reg, ov_next;
  logic              done_reg, done_next;

  logic [SLICE-1:0]  a_cur, b_cur;
  logic [SLICE:0]    slice_sum;
  logic [WIDTH-1:0]  raw;
  logic              ov;
  logic [WIDTH-1:0]  sat_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      c_reg     <= 1'b0;
      sat_reg   <= 1'b0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      ov_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      res_reg   <= res_next;
      c_reg     <= c_next;
      sat_reg   <= sat_next;
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
      ov_reg    <= ov_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    res_next   = res_reg;
    c_next     = c_reg;
    sat_next   = sat_reg;
    sum_next   = sum_reg;
    carry_next = carry_reg;
    ov_next    = ov_reg;
    done_next  = 1'b0;

    // Slice selected by the counter; mux form avoids a zero-width index when N = 1.
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_reg == CW'(i)) begin
        a_cur = a_reg[i*SLICE +: SLICE];
        b_cur = b_reg[i*SLICE +: SLICE];
      end
    end
    slice_sum = {1'b0, a_cur} + {1'b0, b_cur} + (SLICE+1)'(c_reg);

    raw = res_reg;
    for (int i = 0; i < N; i++) begin
      if (cnt_reg == CW'(i)) raw[i*SLICE +: SLICE] = slice_sum[SLICE-1:0];
    end

    ov      = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (raw[WIDTH-1] != a_reg[WIDTH-1]);
    sat_val = a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = A;
          b_next     = op ? ~B : B;
          c_next     = op;
          sat_next   = sat;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        res_next = raw;
        c_next   = slice_sum[SLICE];
        if (cnt_reg == CW'(N-1)) begin
          cnt_next   = '0;
          state_next = IDLE;
          done_next  = 1'b1;
          carry_next = slice_sum[SLICE];
          ov_next    = ov;
          sum_next   = (sat_reg && ov) ? sat_val : raw;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state_reg == RUN);
  assign done     = done_reg;
  assign Sum      = sum_reg;
  assign carry    = carry_reg;
  assign overflow = ov_reg;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: directed cases plus random operations on an 8/4 and a 4/1 instance,
// checked against an integer-arithmetic reference model.
module tb_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0, op8 = 1'b0, sat8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, carry8, ov8;
  logic [7:0] sum8;

  logic       start4 = 1'b0, op4 = 1'b0, sat4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, carry4, ov4;
  logic [3:0] sum4;

  int tests_run = 0;
  int tests_failed = 0;

  bit          sel = 1'b0;
  logic        m_busy, m_done, m_carry, m_ov;
  logic [31:0] m_sum;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8), .SLICE(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .sat(sat8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .Sum(sum8), .carry(carry8), .overflow(ov8)
  );

  serial_add_sub #(.WIDTH(4), .SLICE(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .sat(sat4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .Sum(sum4), .carry(carry4), .overflow(ov4)
  );

  assign m_busy  = sel ? busy4  : busy8;
  assign m_done  = sel ? done4  : done8;
  assign m_carry = sel ? carry4 : carry8;
  assign m_ov    = sel ? ov4    : ov8;
  assign m_sum   = sel ? {28'd0, sum4} : {24'd0, sum8};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact signed arithmetic on integers, then range test and wrap.
  task automatic model(input int w, input int a, input int b, input bit op, input bit sat,
                       output int es, output bit ec, output bit eov);
    int md, sa, sb, exact, mx, mn;
    md    = 1 << w;
    sa    = (a >= md/2) ? a - md : a;
    sb    = (b >= md/2) ? b - md : b;
    exact = op ? sa - sb : sa + sb;
    mx    = md/2 - 1;
    mn    = -(md/2);
    eov   = (exact > mx) || (exact < mn);
    ec    = op ? (a >= b) : (a + b >= md);
    es    = (eov && sat) ? ((exact < 0) ? mn : mx) : exact;
    es    = es & (md - 1);
  endtask

  task automatic do_op(input bit s4, input int a, input int b, input bit op_i, input bit sat_i,
                       input int es, input bit ec, input bit eov, input string tag);
    logic [31:0] prev;
    int edges;
    bit seen;
    int lat;
    lat = s4 ? 4 : 2;
    sel = s4;
    @(negedge clk);
    if (s4) begin
      start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; op4 = op_i; sat4 = sat_i;
    end else begin
      start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; op8 = op_i; sat8 = sat_i;
    end
    prev = m_sum;
    @(posedge clk); #1;
    check({tag, " busy_rise"}, {31'd0, m_busy}, 32'd1);
    @(negedge clk);
    // Operands change during RUN and must not matter.
    if (s4) begin
      start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); op4 = ~op_i; sat4 = ~sat_i;
    end else begin
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = ~op_i; sat8 = ~sat_i;
    end
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 12) begin
      @(posedge clk); #1;
      edges++;
      if (m_done) seen = 1'b1;
      else check({tag, " sum_hold"}, m_sum, prev);
    end
    check({tag, " latency"}, edges, lat);
    check({tag, " sum"}, m_sum, es);
    check({tag, " carry"}, {31'd0, m_carry}, {31'd0, ec});
    check({tag, " overflow"}, {31'd0, m_ov}, {31'd0, eov});
    check({tag, " busy_fall"}, {31'd0, m_busy}, 32'd0);
    $display("[TB] %s w=%0d A=%0h B=%0h op=%0b sat=%0b -> Sum=%0h carry=%0b ov=%0b",
             tag, s4 ? 4 : 8, a, b, op_i, sat_i, m_sum, m_carry, m_ov);
    @(posedge clk); #1;
    check({tag, " done_pulse"}, {31'd0, m_done}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int es;
    bit ec, eov, seen;
    int a, b;
    bit op, sat;

    #2;
    check("reset busy8", {31'd0, busy8}, 32'd0);
    check("reset done8", {31'd0, done8}, 32'd0);
    check("reset sum8", {24'd0, sum8}, 32'd0);
    check("reset carry8", {31'd0, carry8}, 32'd0);
    check("reset ov8", {31'd0, ov8}, 32'd0);
    check("reset sum4", {28'd0, sum4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(0, 'h64, 'h1B, 0, 0, 'h7F, 0, 0, "add_basic");
    do_op(0, 'h64, 'h1C, 0, 0, 'h80, 0, 1, "add_ovf");
    do_op(0, 'h64, 'h1C, 0, 1, 'h7F, 0, 1, "add_ovf_sat");
    do_op(0, 'h80, 'h01, 1, 0, 'h7F, 1, 1, "sub_ovf");
    do_op(0, 'h80, 'h01, 1, 1, 'h80, 1, 1, "sub_ovf_sat");
    do_op(0, 'h05, 'h07, 1, 0, 'hFE, 0, 0, "sub_borrow");
    do_op(1, 'h7, 'h2, 0, 0, 'h9, 0, 1, "w4_add_ovf");
    do_op(1, 'hB, 'hC, 1, 0, 'hF, 0, 0, "w4_sub");

    // start asserted mid-RUN with new operands is ignored
    sel = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; op8 = 1'b0; sat8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h7F; op8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk); #1;
    check("midrun done", {31'd0, done8}, 32'd1);
    check("midrun sum", {24'd0, sum8}, 32'h30);
    check("midrun carry", {31'd0, carry8}, 32'd0);
    @(posedge clk); #1;
    check("midrun not_queued", {31'd0, busy8}, 32'd0);
    $display("[TB] midrun_ignore Sum=%0h", sum8);

    // start held through the done cycle: back-to-back operations
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h64; b8 = 8'h1B; op8 = 1'b0; sat8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h07; op8 = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check("b2b done1", {31'd0, done8}, 32'd1);
    check("b2b sum1", {24'd0, sum8}, 32'h7F);
    @(posedge clk); #1;
    check("b2b busy2", {31'd0, busy8}, 32'd1);
    check("b2b done_low", {31'd0, done8}, 32'd0);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk); #1;
    check("b2b early_done", {31'd0, done8}, 32'd0);
    @(posedge clk); #1;
    check("b2b done2", {31'd0, done8}, 32'd1);
    check("b2b sum2", {24'd0, sum8}, 32'hFE);
    check("b2b carry2", {31'd0, carry8}, 32'd0);
    $display("[TB] back_to_back Sum=%0h", sum8);

    // asynchronous reset in the second RUN cycle
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; op8 = 1'b0; sat8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst busy", {31'd0, busy8}, 32'd0);
    check("rst done", {31'd0, done8}, 32'd0);
    check("rst sum", {24'd0, sum8}, 32'd0);
    check("rst carry", {31'd0, carry8}, 32'd0);
    check("rst ov", {31'd0, ov8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done8 || busy8) seen = 1'b1;
    end
    check("rst no_done", {31'd0, seen}, 32'd0);
    $display("[TB] reset_abort");
    do_op(0, 'h22, 'h33, 0, 0, 'h55, 0, 0, "after_rst");

    repeat (30) begin
      a = int'($urandom_range(255)); b = int'($urandom_range(255));
      op = 1'($urandom); sat = 1'($urandom);
      model(8, a, b, op, sat, es, ec, eov);
      do_op(0, a, b, op, sat, es, ec, eov, "rand8");
    end
    repeat (20) begin
      a = int'($urandom_range(15)); b = int'($urandom_range(15));
      op = 1'($urandom); sat = 1'($urandom);
      model(4, a, b, op, sat, es, ec, eov);
      do_op(1, a, b, op, sat, es, ec, eov, "rand4");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
